nibble_sub_seq: RTL and testbench
=================================

NIBBLE_SUB_SEQ -- requirements
Module: nibble_sub_seq

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, giving the number of 4-bit nibbles per operand (W = 4*NIBBLES).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port start_valid  input  1  high when the operands are presented.
REQ-005 SHALL have port start_ready  output  1  high when the block can accept operands.
REQ-006 SHALL have port a  input  W  minuend.
REQ-007 SHALL have port b  input  W  subtrahend.
REQ-008 SHALL have port bin  input  1  borrow-in to nibble 0.
REQ-009 SHALL have port res_valid  output  1  high when a result is held.
REQ-010 SHALL have port res_ready  input  1  high when the consumer takes the result.
REQ-011 SHALL have port diff  output  W  result a - b - bin, modulo 2^W.
REQ-012 SHALL have port bout  output  1  borrow out of the MSB.
REQ-013 SHALL have port zero  output  1  high when diff == 0.
REQ-014 SHALL have port ovf  output  1  signed (two's-complement) overflow.
REQ-015 SHALL have port busy  output  1  high in RUN.

Function
REQ-016 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-017 In IDLE, start_ready SHALL be 1 and res_valid SHALL be 0.
REQ-018 In IDLE with start_valid=1, the block SHALL capture a, b and bin into internal registers, clear the nibble counter and go to RUN.
REQ-019 In RUN, each cycle SHALL process nibble k = counter.
REQ-020 Nibble k SHALL compute diff_nibble = a_k XOR b_k XOR borrow at every bit.
REQ-021 Each bit of nibble k SHALL compute borrow_next = (~a & b) | (~(a ^ b) & borrow_in), rippled LSB to MSB.
REQ-022 The nibble-k result SHALL be stored in diff[4k+3:4k].
REQ-023 The borrow out of nibble k SHALL be registered as the borrow-in for nibble k+1.
REQ-024 Nibble 0 SHALL use the captured bin as its borrow-in.
REQ-025 After nibble NIBBLES-1 is processed, the FSM SHALL go to DONE; bout SHALL equal that nibble's borrow out.
REQ-026 On entering DONE, the block SHALL register zero = (diff == 0).
REQ-027 On entering DONE, the block SHALL register ovf = (a[W-1] ^ b[W-1]) & (diff[W-1] ^ a[W-1]).
REQ-028 Latency: if the accept occurs at edge T, res_valid SHALL be 1 after edge T+NIBBLES.
REQ-029 In DONE, res_valid SHALL be 1, start_ready SHALL be 0, and diff, bout, zero and ovf SHALL stay stable until the handshake completes.
REQ-030 In DONE with res_ready=1, the FSM SHALL return to IDLE; res_valid SHALL fall after that edge.
REQ-031 diff, bout, zero and ovf SHALL keep their values in IDLE until the next accept.
REQ-032 The earliest new accept SHALL be the cycle after the DONE-to-IDLE transition; an accept and a result handshake SHALL never occur in the same cycle.
REQ-033 start_valid SHALL be ignored in RUN and DONE.
REQ-034 Changes on a, b or bin after the accept SHALL have no effect.
REQ-035 The nibble counter SHALL be ceil(log2(NIBBLES)) bits wide, minimum 1 bit, and SHALL never exceed NIBBLES-1.
REQ-036 When NIBBLES=1, RUN SHALL last exactly one cycle.
REQ-037 res_ready SHALL be ignored outside DONE.

Reset
REQ-038 reset=1 at a rising edge SHALL force IDLE and clear the counter and internal borrow, and drive diff=0, bout=0, zero=0, ovf=0, res_valid=0 and busy=0; start_ready SHALL read 1 after the edge.
REQ-039 reset SHALL take priority over every other input in every state; a reset during RUN or DONE SHALL abort the operation with no res_valid pulse.

Verification (NIBBLES=4)
REQ-040 Basic subtract: a=0x1234, b=0x0234, bin=0 accepted at edge T -> after edge T+4, res_valid=1, diff=0x1000, bout=0, zero=0, ovf=0.
REQ-041 Unsigned underflow: a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, zero=0, ovf=0.
REQ-042 Signed overflow: a=0x8000, b=0x0001, bin=0 -> diff=0x7FFF, bout=0, ovf=1.
REQ-043 Borrow-in to zero: a=0x0005, b=0x0004, bin=1 -> diff=0x0000, zero=1, bout=0.
REQ-044 Backpressure: hold res_ready=0 for 3 cycles in DONE while pulsing start_valid with new operands -> outputs stay stable, start_ready=0, no new accept; then res_ready=1 -> IDLE next cycle.
REQ-045 Mid-operation reset: assert reset on the second RUN cycle -> next cycle IDLE, all outputs 0, start_ready=1, no res_valid.

Source files
------------

// File: rtl/nibble_sub_seq.sv
// Nibble-serial subtractor: diff = a - b - bin, one 4-bit nibble per cycle,
// with valid/ready handshakes on operand accept and result delivery.
module nibble_sub_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 bin,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [4*NIBBLES-1:0] diff,
  output logic                 bout,
  output logic                 zero,
  output logic                 ovf,
  output logic                 busy
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state, state_nx;
  logic [W-1:0]    a_r, b_r;
  logic            borrow_r;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    diff_r;
  logic            bout_r, zero_r, ovf_r;

  logic [3:0]      a_nib, b_nib, d_nib;
  logic [4:0]      brw;
  logic            nib_bout;
  logic [W-1:0]    diff_nx;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_valid) state_nx = RUN;
      RUN:     if (cnt == LAST) state_nx = DONE;
      DONE:    if (res_ready)   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    start_ready = (state == IDLE);
    res_valid   = (state == DONE);
    busy        = (state == RUN);
  end

  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int unsigned k = 0; k < NIBBLES; k++) begin
      if (cnt == CW'(k)) begin
        a_nib = a_r[4*k +: 4];
        b_nib = b_r[4*k +: 4];
      end
    end
  end

  // Bit-level borrow ripple inside the current nibble.
  always_comb begin
    brw    = '0;
    d_nib  = '0;
    brw[0] = borrow_r;
    for (int unsigned i = 0; i < 4; i++) begin
      d_nib[i]   = a_nib[i] ^ b_nib[i] ^ brw[i];
      brw[i+1]   = (~a_nib[i] & b_nib[i]) | (~(a_nib[i] ^ b_nib[i]) & brw[i]);
    end
    nib_bout = brw[4];
  end

  always_comb begin
    diff_nx = diff_r;
    for (int unsigned k = 0; k < NIBBLES; k++) begin
      if (cnt == CW'(k)) diff_nx[4*k +: 4] = d_nib;
    end
  end

  // Flags are taken from diff_nx so they reflect the final nibble on DONE entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r      <= '0;
      b_r      <= '0;
      borrow_r <= 1'b0;
      cnt      <= '0;
      diff_r   <= '0;
      bout_r   <= 1'b0;
      zero_r   <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_r      <= a;
            b_r      <= b;
            borrow_r <= bin;
            cnt      <= '0;
          end
        end
        RUN: begin
          diff_r   <= diff_nx;
          borrow_r <= nib_bout;
          if (cnt == LAST) begin
            bout_r <= nib_bout;
            zero_r <= (diff_nx == '0);
            ovf_r  <= (a_r[W-1] ^ b_r[W-1]) & (diff_nx[W-1] ^ a_r[W-1]);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    diff = diff_r;
    bout = bout_r;
    zero = zero_r;
    ovf  = ovf_r;
  end

endmodule

// File: tb/tb_nibble_sub_seq.sv
// Self-checking bench for nibble_sub_seq: arithmetic/timing reference model,
// directed corner cases and randomized traffic.
module tb_nibble_sub_seq;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         reset, start_valid, start_ready, bin;
  logic         res_valid, res_ready, bout, zero, ovf, busy;
  logic [W-1:0] a, b, diff;

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  nibble_sub_seq #(.NIBBLES(N)) dut (
    .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(start_ready),
    .a(a), .b(b), .bin(bin), .res_valid(res_valid), .res_ready(res_ready),
    .diff(diff), .bout(bout), .zero(zero), .ovf(ovf), .busy(busy)
  );

  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
    logic         z;
    logic         ov;
  } res_t;

  // Reference result from plain wide integer arithmetic.
  function automatic res_t ref_sub(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    res_t   r;
    longint ux, uy, sx, sy, sd, lim;
    ux   = longint'(x);
    uy   = longint'(y);
    sx   = longint'($signed(x));
    sy   = longint'($signed(y));
    lim  = longint'(1) <<< (W - 1);
    r.d  = W'(ux - uy - longint'(ci));
    r.bo = (ux < uy + longint'(ci));
    sd   = sx - sy - longint'(ci);
    r.ov = (sd < -lim) || (sd >= lim);
    r.z  = (r.d == '0);
    return r;
  endfunction

  // Timing model: accepted op becomes visible N edges later, held until taken.
  logic         m_busy, m_valid;
  int           m_left;
  res_t         pend;
  logic [W-1:0] m_diff;
  logic         m_bout, m_zero, m_ovf;

  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 1'b0; m_valid <= 1'b0; m_left <= 0;
      m_diff <= '0; m_bout <= 1'b0; m_zero <= 1'b0; m_ovf <= 1'b0;
    end else if (m_busy) begin
      if (m_left == 1) begin
        m_busy <= 1'b0; m_valid <= 1'b1;
        m_diff <= pend.d; m_bout <= pend.bo; m_zero <= pend.z; m_ovf <= pend.ov;
      end
      m_left <= m_left - 1;
    end else if (m_valid) begin
      if (res_ready) m_valid <= 1'b0;
    end else if (start_valid) begin
      pend   <= ref_sub(a, b, bin);
      m_busy <= 1'b1;
      m_left <= N;
    end
  end

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check1("start_ready", start_ready, !m_busy && !m_valid);
      check1("res_valid", res_valid, m_valid);
      check1("busy", busy, m_busy);
      if (!m_busy) begin
        checkw("diff", diff, m_diff);
        check1("bout", bout, m_bout);
        check1("zero", zero, m_zero);
        check1("ovf", ovf, m_ovf);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one op, measure latency, compare against literal expectations.
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                       input logic [W-1:0] ed, input logic eb, input logic ez, input logic eo,
                       input logic take);
    int cyc;
    check1("ready_before_accept", start_ready, 1'b1);
    a = x; b = y; bin = ci; start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    a = W'($urandom()); b = W'($urandom()); bin = 1'($urandom());
    cyc = 0;
    while (!res_valid && cyc < 50) begin
      tick();
      cyc++;
      a = W'($urandom()); b = W'($urandom());
    end
    checki("latency", cyc, N);
    checkw("lit_diff", diff, ed);
    check1("lit_bout", bout, eb);
    check1("lit_zero", zero, ez);
    check1("lit_ovf", ovf, eo);
    if (take) begin
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check1("after_take_valid", res_valid, 1'b0);
      check1("after_take_ready", start_ready, 1'b1);
    end
  endtask

  initial begin
    logic [W-1:0] held;
    reset = 1'b1; start_valid = 1'b0; res_ready = 1'b0;
    a = '0; b = '0; bin = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    chk_en = 1'b1;
    check1("rst_start_ready", start_ready, 1'b1);
    check1("rst_res_valid", res_valid, 1'b0);
    checkw("rst_diff", diff, '0);
    check1("rst_busy", busy, 1'b0);

    do_op(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b1);
    do_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1);
    do_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b1);
    do_op(16'h0005, 16'h0004, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
    do_op(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b1);

    // Backpressure: result held while new operands are offered.
    do_op(16'hABCD, 16'h1111, 1'b1, 16'h9ABB, 1'b0, 1'b0, 1'b0, 1'b0);
    held = diff;
    for (int i = 0; i < 3; i++) begin
      start_valid = 1'b1; a = W'($urandom()); b = W'($urandom());
      tick();
      check1("bp_start_ready", start_ready, 1'b0);
      check1("bp_res_valid", res_valid, 1'b1);
      checkw("bp_diff", diff, held);
    end
    start_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check1("bp_release_valid", res_valid, 1'b0);
    check1("bp_release_ready", start_ready, 1'b1);

    // Reset on the second RUN cycle aborts the operation.
    a = 16'h1234; b = 16'h4321; bin = 1'b0; start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check1("mrst_start_ready", start_ready, 1'b1);
    check1("mrst_busy", busy, 1'b0);
    checkw("mrst_diff", diff, '0);
    check1("mrst_bout", bout, 1'b0);
    check1("mrst_ovf", ovf, 1'b0);
    begin
      int seen = 0;
      for (int i = 0; i < N + 2; i++) begin
        tick();
        if (res_valid) seen++;
      end
      checki("mrst_no_valid", seen, 0);
    end

    // Random traffic; operands keep changing so late changes must be ignored.
    for (int i = 0; i < 1500; i++) begin
      start_valid = 1'($urandom_range(0, 1));
      res_ready   = ($urandom_range(0, 2) == 0);
      reset       = ($urandom_range(0, 79) == 0);
      a   = W'($urandom());
      b   = ($urandom_range(0, 7) == 0) ? a : W'($urandom());
      bin = 1'($urandom());
      tick();
    end
    reset = 1'b0; start_valid = 1'b0; res_ready = 1'b1;
    repeat (N + 3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
